// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: N-light fill, LFSR-random hold, lights-out, reaction timing.
// Optional jump-start detection (FAULT state) is enabled by defining F1_JUMP_START_EN.
module f1_light_seq #(
  parameter int N_LIGHTS = 8,
  parameter int HOLD_W   = 4,
  parameter int HOLD_MIN = 2,
  parameter int REACT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trigger,
  input  logic                react,
  output logic [N_LIGHTS-1:0] lights,
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic                busy,
  output logic [REACT_W-1:0]  reaction_time,
  output logic                result_valid,
  output logic                jump_start
);

`ifdef F1_JUMP_START_EN
  localparam bit JS_EN = 1'b1;
`else
  localparam bit JS_EN = 1'b0;
`endif

  localparam logic [REACT_W-1:0] REACT_ONE = 1;

  typedef enum logic [2:0] {IDLE, FILL, HOLD, OUT, DONE, FAULT} state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [8:0]         hold_cnt;
  logic [REACT_W-1:0] react_cnt;
  logic               lfsr_fb;
  logic [8:0]         hold_load;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign hold_load = 9'(HOLD_MIN) + 9'(lfsr[HOLD_W-1:0]);

  assign cmd_seq    = (state == IDLE) || (state == FILL);
  assign cmd_delay  = (state == HOLD);
  assign busy       = (state == FILL) || (state == HOLD) || (state == OUT);
  assign jump_start = JS_EN && (state == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lights        <= '0;
      reaction_time <= '0;
      result_valid  <= 1'b0;
      lfsr          <= 16'hACE1;
      hold_cnt      <= '0;
      react_cnt     <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) state <= FILL;
        end
        // A press during FILL/HOLD beats any tick arriving in the same cycle.
        FILL: begin
          if (JS_EN && react) begin
            state  <= FAULT;
            lights <= '1;
          end else if (tick) begin
            lights <= {lights[N_LIGHTS-2:0], 1'b1};
            if (&lights[N_LIGHTS-2:0]) begin
              state    <= HOLD;
              hold_cnt <= hold_load;
            end
          end
        end
        HOLD: begin
          if (JS_EN && react) begin
            state <= FAULT;
          end else if (tick) begin
            if (hold_cnt == '0) begin
              state     <= OUT;
              lights    <= '0;
              react_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt - 9'd1;
            end
          end
        end
        // reaction_time captures the pre-increment count, so an immediate press reads 0.
        OUT: begin
          if (react_cnt != '1) react_cnt <= react_cnt + REACT_ONE;
          if (react) begin
            state         <= DONE;
            reaction_time <= react_cnt;
            result_valid  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          if (trigger) begin
            state  <= IDLE;
            lights <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// Randomized self-checking bench for f1_light_seq against a phase/count reference model.
// A second instance with REACT_W = 4 runs in lockstep to cover reaction-counter saturation.
module tb_f1_light_seq;

  localparam int N    = 8;
  localparam int HW   = 4;
  localparam int HMIN = 2;
  localparam int RW   = 16;
  localparam int RW4  = 4;

`ifdef F1_JUMP_START_EN
  localparam bit JS = 1'b1;
`else
  localparam bit JS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic trigger = 1'b0;
  logic react = 1'b0;

  logic [N-1:0]   lights, lights4;
  logic           cmd_seq, cmd_delay, busy, result_valid, jump_start;
  logic           cmd_seq4, cmd_delay4, busy4, result_valid4, jump_start4;
  logic [RW-1:0]  reaction_time;
  logic [RW4-1:0] reaction_time4;

  int n_checks = 0;
  int n_errors = 0;

  f1_light_seq #(.N_LIGHTS(N), .HOLD_W(HW), .HOLD_MIN(HMIN), .REACT_W(RW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
    .lights(lights), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .busy(busy),
    .reaction_time(reaction_time), .result_valid(result_valid), .jump_start(jump_start)
  );

  f1_light_seq #(.N_LIGHTS(N), .HOLD_W(HW), .HOLD_MIN(HMIN), .REACT_W(RW4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .react(react),
    .lights(lights4), .cmd_seq(cmd_seq4), .cmd_delay(cmd_delay4), .busy(busy4),
    .reaction_time(reaction_time4), .result_valid(result_valid4), .jump_start(jump_start4)
  );

  always #5 clk = ~clk;

  // Tick source: fixed 1-in-4 by default, random gaps of 1..5 when tick_rand is set.
  bit tick_rand = 1'b0;
  int gap_cnt = 0;
  int cur_gap = 4;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (gap_cnt >= cur_gap - 1) begin
        tick = 1'b1;
        gap_cnt = 0;
        cur_gap = tick_rand ? int'($urandom_range(1, 5)) : 4;
      end else begin
        tick = 1'b0;
        gap_cnt++;
      end
    end
  end

  // Reference model: counts lit lamps, remaining hold ticks and elapsed out cycles.
  typedef enum {M_IDLE, M_FILL, M_HOLD, M_OUT, M_DONE, M_FAULT} mphase_t;
  mphase_t     phase = M_IDLE;
  int          n_lit = 0, hold_left = 0, out_k = 0, m_r = 0;
  int          exp_rt = 0, exp_rt4 = 0;
  bit          exp_valid = 1'b0;
  bit          model_ready = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) begin
    if (rst) begin
      phase = M_IDLE; n_lit = 0; hold_left = 0; out_k = 0;
      exp_rt = 0; exp_rt4 = 0; exp_valid = 1'b0;
      m_lfsr = 16'hACE1;
      model_ready = 1'b1;
    end else begin
      m_r = int'(m_lfsr) % (1 << HW);
      exp_valid = 1'b0;
      case (phase)
        M_IDLE:  if (trigger) begin phase = M_FILL; n_lit = 0; end
        M_FILL: begin
          if (JS && react) phase = M_FAULT;
          else if (tick) begin
            n_lit++;
            if (n_lit == N) begin phase = M_HOLD; hold_left = HMIN + m_r + 1; end
          end
        end
        M_HOLD: begin
          if (JS && react) phase = M_FAULT;
          else if (tick) begin
            hold_left--;
            if (hold_left == 0) begin phase = M_OUT; out_k = 0; end
          end
        end
        M_OUT: begin
          if (react) begin
            exp_rt  = (out_k < (1 << RW) - 1) ? out_k : (1 << RW) - 1;
            exp_rt4 = (out_k < 15) ? out_k : 15;
            exp_valid = 1'b1;
            phase = M_DONE;
          end
          out_k++;
        end
        M_DONE:  phase = M_IDLE;
        M_FAULT: if (trigger) phase = M_IDLE;
        default: phase = M_IDLE;
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic logic [N-1:0] expLights();
    case (phase)
      M_FILL:           return N'((1 << n_lit) - 1);
      M_HOLD, M_FAULT:  return '1;
      default:          return '0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic r);
    trigger = t;
    react   = r;
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cycle_main",
        64'({lights, cmd_seq, cmd_delay, busy, result_valid, jump_start, reaction_time}),
        64'({expLights(), phase == M_IDLE || phase == M_FILL, phase == M_HOLD,
             phase == M_FILL || phase == M_HOLD || phase == M_OUT, exp_valid,
             phase == M_FAULT, RW'(exp_rt)}));
      checkOutput("cycle_sat",
        64'({lights4, cmd_seq4, cmd_delay4, busy4, result_valid4, jump_start4, reaction_time4}),
        64'({expLights(), phase == M_IDLE || phase == M_FILL, phase == M_HOLD,
             phase == M_FILL || phase == M_HOLD || phase == M_OUT, exp_valid,
             phase == M_FAULT, RW4'(exp_rt4)}));
    end
  end

  task automatic pulseTrigger();
    @(posedge clk); #2 applyStimulus(1'b1, 1'b0);
    @(posedge clk); #2 applyStimulus(1'b0, 1'b0);
  endtask

  task automatic waitTick();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tick) begin seen = 1'b1; break; end
    end
    if (!seen) checkOutput("tick_timeout", 64'd0, 64'd1);
  endtask

  // Returns at the negedge of the first lights-out cycle, with the number of HOLD ticks seen.
  task automatic waitOut(output int hold_ticks);
    bit ok = 1'b0;
    hold_ticks = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cmd_delay && tick) hold_ticks++;
      if (busy && !cmd_seq && !cmd_delay) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("wait_out_timeout", 64'd0, 64'd1);
  endtask

  // Holds react during the out cycle numbered 'delay'; returns at the negedge of the DONE cycle.
  task automatic pressReact(input int delay);
    if (delay == 0) react = 1'b1;
    else begin
      repeat (delay) @(posedge clk);
      #2 react = 1'b1;
    end
    @(posedge clk); #2 react = 1'b0;
    @(negedge clk);
  endtask

  task automatic runStart(input int delay, output int hold_ticks);
    pulseTrigger();
    waitOut(hold_ticks);
    pressReact(delay);
  endtask

  bit [31:0] seen_hold = '0;

  task automatic noteHold(input int h);
    checkOutput("hold_range", 64'(h >= HMIN + 1 && h <= HMIN + (1 << HW)), 64'd1);
    if (h >= 0 && h < 32) seen_hold[h] = 1'b1;
  endtask

  initial begin
    int  h;
    bit  found;

    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_lights", 64'(lights), 64'd0);
    checkOutput("rst_cmd_seq", 64'(cmd_seq), 64'd1);
    checkOutput("rst_cmd_delay", 64'(cmd_delay), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_reaction", 64'(reaction_time), 64'd0);
    checkOutput("rst_valid", 64'(result_valid), 64'd0);

    pulseTrigger();
    for (int i = 1; i <= N; i++) begin
      waitTick();
      @(negedge clk);
      checkOutput($sformatf("fill_lights_%0d", i), 64'(lights), 64'((1 << i) - 1));
    end
    checkOutput("hold_cmd_seq", 64'(cmd_seq), 64'd0);
    checkOutput("hold_cmd_delay", 64'(cmd_delay), 64'd1);

    waitOut(h);
    noteHold(h);
    pressReact(37);
    checkOutput("react37_time", 64'(reaction_time), 64'd37);
    checkOutput("react37_valid", 64'(result_valid), 64'd1);
    @(negedge clk);
    checkOutput("react37_valid_drop", 64'(result_valid), 64'd0);
    checkOutput("react37_idle", 64'({cmd_seq, busy}), 64'b10);

    runStart(20, h);
    noteHold(h);
    checkOutput("sat_react4", 64'(reaction_time4), 64'd15);
    checkOutput("sat_react16", 64'(reaction_time), 64'd20);

    tick_rand = 1'b1;
    for (int s = 0; s < 50; s++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      runStart(int'($urandom_range(0, 40)), h);
      noteHold(h);
    end
    checkOutput("hold_distinct", 64'($countones(seen_hold) >= 2), 64'd1);

    pulseTrigger();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_state", 64'({lights, cmd_seq, busy}), 64'({8'h00, 1'b1, 1'b0}));

    tick_rand = 1'b0;
    pulseTrigger();
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lights == 8'h07) begin found = 1'b1; break; end
    end
    if (!found) checkOutput("jump_wait_timeout", 64'd0, 64'd1);
    react = 1'b1;
    @(posedge clk); #2 react = 1'b0;
    @(negedge clk);
`ifdef F1_JUMP_START_EN
    checkOutput("jump_lights", 64'(lights), 64'hFF);
    checkOutput("jump_flag", 64'(jump_start), 64'd1);
    checkOutput("jump_no_valid", 64'(result_valid), 64'd0);
    repeat (10) @(negedge clk);
    checkOutput("jump_stays", 64'({jump_start, busy}), 64'b10);
    pulseTrigger();
    @(negedge clk);
    checkOutput("jump_cleared", 64'({lights, jump_start, cmd_seq, busy}), 64'({8'h00, 1'b0, 1'b1, 1'b0}));
`else
    checkOutput("nojump_flag", 64'(jump_start), 64'd0);
    checkOutput("nojump_lights", 64'(lights == 8'h07 || lights == 8'h0F), 64'd1);
    waitOut(h);
    noteHold(h);
    pressReact(5);
    checkOutput("nojump_react", 64'(reaction_time), 64'd5);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
- Parametrised F1 start-light sequencer with an N-light fill, a pseudo-random hold, lights-out, and driver reaction timing.
- Sits between the tick/clock-divider block (source of `tick`), the driver push-button inputs, and the LED bank.
- Drives `cmd_seq`/`cmd_delay` so the tick source and the delay block can be switched by phase.

Parameters:
- N_LIGHTS, 8, number of start lights; legal range 2..32.
- HOLD_W, 4, LFSR bits used for the random hold; legal range 1..8.
- HOLD_MIN, 2, minimum hold load in ticks; legal range 0..255.
- REACT_W, 16, width of the reaction-time counter, in clk cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle step enable from the tick generator
- trigger  in  1  start request, level-sampled on clk
- react  in  1  driver button, level-sampled on clk
- lights  out  N_LIGHTS  light pattern; bit0 lights first
- cmd_seq  out  1  high in IDLE and FILL
- cmd_delay  out  1  high in HOLD
- busy  out  1  high in FILL, HOLD and OUT
- reaction_time  out  REACT_W  last measured reaction, in clk cycles
- result_valid  out  1  one-cycle pulse when reaction_time updates
- jump_start  out  1  high in FAULT

Behaviour:
- Decided interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state = IDLE, lights = 0, reaction_time = 0.
  - result_valid = 0, jump_start = 0.
  - LFSR = 16'hACE1; hold and reaction counters = 0.
  - Resulting outputs: cmd_seq = 1, cmd_delay = 0, busy = 0.
  - Reset mid-operation aborts any state in one edge.
- LFSR:
  - 16-bit Fibonacci, advances every clk cycle regardless of state.
  - feedback = b15^b13^b12^b10, shifted into bit0.
  - r = lfsr[HOLD_W-1:0], sampled at the FILL->HOLD edge.
- IDLE:
  - lights = 0.
  - trigger = 1 -> FILL at the next edge; tick is not required.
- FILL:
  - On each tick, lights <= {lights[N-2:0], 1'b1}.
  - The tick that makes lights all-ones also moves to HOLD and loads the hold counter with HOLD_MIN + r (9-bit, no overflow).
  - FILL therefore lasts exactly N_LIGHTS ticks.
- HOLD:
  - lights stay all-ones.
  - On tick: if counter == 0 -> OUT, lights <= 0, reaction counter <= 0; else counter decrements.
  - HOLD therefore lasts HOLD_MIN + r + 1 ticks.
- OUT:
  - The reaction counter increments every clk cycle and saturates at all-ones.
  - react = 1 -> DONE; reaction_time <= current counter value, which is pre-increment, so react in the first OUT cycle gives 0.
  - result_valid pulses for the edge into DONE.
- DONE:
  - Single cycle, then IDLE.
  - reaction_time holds until the next measurement.
- FAULT (jump start):
  - Entered when react = 1 in FILL or HOLD.
  - react has priority over tick, including a tick with hold counter == 0.
  - In FAULT: lights = all-ones, jump_start = 1, reaction_time unchanged, no result_valid.
  - trigger = 1 -> IDLE; a fresh trigger is then required to start.
- trigger is ignored outside IDLE and FAULT.
- tick has no effect in IDLE, OUT, DONE or FAULT.

Optional Feature:
- Macro: F1_JUMP_START_EN.
- Defined:
  - FAULT state and jump-start detection exist as above.
- Undefined:
  - react is ignored in FILL and HOLD.
  - FAULT is unreachable and jump_start is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst 2 cycles -> lights = 0, cmd_seq = 1, cmd_delay = 0, busy = 0, reaction_time = 0, result_valid = 0.
- Fill sequence (N_LIGHTS = 8, tick every 4 clk): pulse trigger -> after ticks 1..8 lights = 01, 03, 07, ..., FF; state is HOLD after tick 8, cmd_seq = 0, cmd_delay = 1.
- Random hold range (HOLD_W = 4, HOLD_MIN = 2): run 50 starts -> HOLD tick count always within 3..18; at least two distinct values observed.
- Reaction measure: assert react exactly 37 clk cycles after lights go 0 -> reaction_time = 37, result_valid high for one cycle, state back to IDLE next cycle.
- Saturation (REACT_W = 4): withhold react for 20 cycles after lights-out, then press -> reaction_time = 15.
- Jump start: react during FILL (lights = 07) -> next edge lights = FF, jump_start = 1, no result_valid; trigger -> IDLE. With F1_JUMP_START_EN undefined, the same stimulus keeps the sequence running and jump_start stays 0.
